// File: rtl/freelist.sv
// Circular free list of physical register tags: offers up to SUPERSCALAR_WAYS tags per cycle,
// reclaims retired Told tags, and restores the architectural free set in one cycle on flush.
module freelist #(
  parameter int SUPERSCALAR_WAYS = 2,
  parameter int N_PHYS_REG       = 64,
  parameter int N_ARCH_REG       = 32,
  parameter int FL_SIZE          = N_PHYS_REG - N_ARCH_REG,
  parameter int PR_BITS          = $clog2(N_PHYS_REG),
  parameter int CNT_BITS         = $clog2(FL_SIZE) + 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [SUPERSCALAR_WAYS-1:0]         new_pr_en,
  input  logic [SUPERSCALAR_WAYS-1:0]         retire_en,
  input  logic [SUPERSCALAR_WAYS*PR_BITS-1:0] retire_told,
  input  logic                                branch_flush_en,
  output logic [SUPERSCALAR_WAYS*PR_BITS-1:0] t_idx,
  output logic [SUPERSCALAR_WAYS-1:0]         t_valid,
  output logic [CNT_BITS-1:0]                 free_cnt
);

  localparam int PTR_BITS = $clog2(FL_SIZE);

  logic [PR_BITS-1:0]  r_entry [FL_SIZE];
  logic [PTR_BITS-1:0] r_head;
  logic [PTR_BITS-1:0] r_retire_head;
  logic [PTR_BITS-1:0] r_tail;
  logic [CNT_BITS-1:0] r_count;

  logic [CNT_BITS-1:0] w_npop_req;
  logic [CNT_BITS-1:0] w_npop;
  logic [CNT_BITS-1:0] w_nret;
  logic [PTR_BITS-1:0] w_push_ptr [SUPERSCALAR_WAYS];

  // Pop/push counts; each retiring way writes at tail plus the number of lower retiring ways.
  always_comb begin
    w_npop_req = '0;
    w_nret     = '0;
    for (int k = 0; k < SUPERSCALAR_WAYS; k++) begin
      w_push_ptr[k] = r_tail + PTR_BITS'(w_nret);
      if (retire_en[k]) begin
        w_nret = w_nret + CNT_BITS'(1);
      end else begin
        w_nret = w_nret;
      end
      if (new_pr_en[k] && !branch_flush_en) begin
        w_npop_req = w_npop_req + CNT_BITS'(1);
      end else begin
        w_npop_req = w_npop_req;
      end
    end
    if (w_npop_req > r_count) begin
      w_npop = r_count;
    end else begin
      w_npop = w_npop_req;
    end
  end

  // Offered tags come straight from registered state; no bypass of same-cycle pushes.
  always_comb begin
    t_idx   = '0;
    t_valid = '0;
    for (int k = 0; k < SUPERSCALAR_WAYS; k++) begin
      t_idx[k*PR_BITS +: PR_BITS] = r_entry[r_head + PTR_BITS'(k)];
      t_valid[k]                  = (CNT_BITS'(k) < r_count);
    end
    free_cnt = r_count;
  end

  // Tag storage: preloaded with the non-architectural tags, refilled by retirement.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < FL_SIZE; j++) begin
        r_entry[j] <= PR_BITS'(N_ARCH_REG + j);
      end
    end else begin
      for (int k = 0; k < SUPERSCALAR_WAYS; k++) begin
        if (retire_en[k]) begin
          r_entry[w_push_ptr[k]] <= retire_told[k*PR_BITS +: PR_BITS];
        end else begin
          r_entry[w_push_ptr[k]] <= r_entry[w_push_ptr[k]];
        end
      end
    end
  end

  // Pointers and count; a flush rewinds head to the retirement point so the whole ring is free.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head        <= '0;
      r_retire_head <= '0;
      r_tail        <= '0;
      r_count       <= CNT_BITS'(FL_SIZE);
    end else begin
      r_tail        <= r_tail + PTR_BITS'(w_nret);
      r_retire_head <= r_retire_head + PTR_BITS'(w_nret);
      if (branch_flush_en) begin
        r_head  <= r_retire_head + PTR_BITS'(w_nret);
        r_count <= CNT_BITS'(FL_SIZE);
      end else begin
        r_head  <= r_head + PTR_BITS'(w_npop);
        r_count <= r_count - w_npop + w_nret;
      end
    end
  end

  freelist_chk #(
    .FL_SIZE  (FL_SIZE),
    .CNT_BITS (CNT_BITS)
  ) u_chk (
    .clock      (clock),
    .reset      (reset),
    .npop_req   (w_npop_req),
    .nret       (w_nret),
    .count      (r_count)
  );

endmodule

// Protocol checks: no over-allocation and no reclaim beyond capacity.
module freelist_chk #(
  parameter int FL_SIZE  = 32,
  parameter int CNT_BITS = 6
) (
  input logic                clock,
  input logic                reset,
  input logic [CNT_BITS-1:0] npop_req,
  input logic [CNT_BITS-1:0] nret,
  input logic [CNT_BITS-1:0] count
);

  // Sampled on every active edge outside reset.
  always @(posedge clock) begin
    if (reset) begin
      assert (int'(npop_req) <= int'(count))
        else $error("freelist: allocation request %0d exceeds free count %0d", npop_req, count);
      assert (int'(count) + int'(nret) - int'(npop_req) <= FL_SIZE)
        else $error("freelist: reclaim overflows free list (count %0d, ret %0d)", count, nret);
    end else begin
    end
  end

endmodule

// File: tb/tb_freelist.sv
// Directed and random checks of freelist against a queue model of the tag ring.
module tb_freelist;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  new_pr_en = 2'b00;
  logic [1:0]  retire_en = 2'b00;
  logic [11:0] retire_told = 12'd0;
  logic        branch_flush_en = 1'b0;
  logic [11:0] t_idx;
  logic [1:0]  t_valid;
  logic [5:0]  free_cnt;

  typedef struct packed {
    logic [11:0] idx;
    logic [1:0]  valid;
    logic [5:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   ring[$];
  int   n_alloc;
  int   tests = 0;
  int   fails = 0;

  freelist dut (
    .clock           (clock),
    .reset           (reset),
    .new_pr_en       (new_pr_en),
    .retire_en       (retire_en),
    .retire_told     (retire_told),
    .branch_flush_en (branch_flush_en),
    .t_idx           (t_idx),
    .t_valid         (t_valid),
    .free_cnt        (free_cnt)
  );

  always #5 clock = ~clock;

  // ring holds the 32 tags in order from the retirement point; the first n_alloc are in use
  function automatic void model_reset();
    ring.delete();
    for (int j = 0; j < 32; j++) ring.push_back(32 + j);
    n_alloc = 0;
  endfunction

  function automatic exp_t model_expect();
    exp_t e;
    int   cnt;
    e   = '0;
    cnt = 32 - n_alloc;
    e.cnt = 6'(cnt);
    for (int k = 0; k < 2; k++) begin
      if (k < cnt) begin
        e.valid[k]       = 1'b1;
        e.idx[k*6 +: 6]  = 6'(ring[n_alloc + k]);
      end
    end
    return e;
  endfunction

  task automatic check(input string tag);
    exp_t e;
    logic [5:0] got_i;
    logic [5:0] exp_i;
    e = sb.pop_front();
    tests++;
    assert (free_cnt === e.cnt) else begin
      fails++;
      $error("FAIL %s free_cnt observed=%0d expected=%0d", tag, free_cnt, e.cnt);
    end
    tests++;
    assert (t_valid === e.valid) else begin
      fails++;
      $error("FAIL %s t_valid observed=%b expected=%b", tag, t_valid, e.valid);
    end
    for (int k = 0; k < 2; k++) begin
      if (e.valid[k]) begin
        got_i = t_idx[k*6 +: 6];
        exp_i = e.idx[k*6 +: 6];
        tests++;
        assert (got_i === exp_i) else begin
          fails++;
          $error("FAIL %s t_idx[%0d] observed=%0d expected=%0d", tag, k, got_i, exp_i);
        end
      end
    end
  endtask

  // Asynchronous reset, checked before any clock edge, then released away from the edge.
  task automatic do_reset(input string tag);
    new_pr_en       = 2'b00;
    retire_en       = 2'b00;
    branch_flush_en = 1'b0;
    reset           = 1'b0;
    model_reset();
    #2;
    sb.push_back(model_expect());
    check(tag);
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic step(input string tag, input logic [1:0] pop, input logic [1:0] ret,
                      input int t0, input int t1, input logic fl);
    int npop;
    new_pr_en       = pop;
    retire_en       = ret;
    retire_told     = {t1[5:0], t0[5:0]};
    branch_flush_en = fl;
    npop = fl ? 0 : $countones(pop);
    if (npop > 32 - n_alloc) npop = 32 - n_alloc;
    n_alloc += npop;
    for (int k = 0; k < 2; k++) begin
      if (ret[k]) begin
        void'(ring.pop_front());
        ring.push_back(k == 0 ? t0 : t1);
        n_alloc--;
      end
    end
    if (fl) n_alloc = 0;
    sb.push_back(model_expect());
    @(posedge clock);
    #1;
    new_pr_en       = 2'b00;
    retire_en       = 2'b00;
    branch_flush_en = 1'b0;
    check(tag);
  endtask

  initial begin
    #3;
    do_reset("reset");
    step("pop11", 2'b11, 2'b00, 0, 0, 1'b0);
    step("pop11_again", 2'b11, 2'b00, 0, 0, 1'b0);
    do_reset("reset_midop");
    step("pop10", 2'b10, 2'b00, 0, 0, 1'b0);

    do_reset("reset_drain");
    for (int i = 0; i < 15; i++) step("drain", 2'b11, 2'b00, 0, 0, 1'b0);
    step("cnt1", 2'b01, 2'b00, 0, 0, 1'b0);
    step("cnt0", 2'b01, 2'b00, 0, 0, 1'b0);
    step("ret_at_empty", 2'b00, 2'b11, 9, 10, 1'b0);

    do_reset("reset_c5");
    for (int i = 0; i < 14; i++) step("to_cnt4", 2'b11, 2'b00, 0, 0, 1'b0);
    step("popret_cnt4", 2'b11, 2'b11, 5, 7, 1'b0);
    step("told_offered", 2'b11, 2'b00, 0, 0, 1'b0);

    do_reset("reset_c6");
    step("pop2a", 2'b11, 2'b00, 0, 0, 1'b0);
    step("pop2b", 2'b11, 2'b00, 0, 0, 1'b0);
    step("flush_ret", 2'b11, 2'b01, 3, 0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      logic [1:0] p;
      logic [1:0] r;
      logic       f;
      int         lim;
      f = ($urandom_range(0, 15) == 0);
      p = 2'($urandom_range(0, 3));
      if (!f && $countones(p) > 32 - n_alloc) p = 2'b00;
      lim = n_alloc + (f ? 0 : $countones(p));
      r = 2'($urandom_range(0, 3));
      if ($countones(r) > lim) r = 2'b00;
      step("random", p, r, $urandom_range(0, 63), $urandom_range(0, 63), f);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
